// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Data cache handshake phases: idle, access outstanding, access just completed.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between the ID/EX load and the IF/ID consumer.
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller gates the result with its own freeze condition.
// Ports: idex_memread/idex_rt describe the producer, ifid_rs/ifid_rt/ifid_uses_rt
//        the consumer; load_use is high when the consumer needs the loaded value.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  output logic             load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (idex_rt == ifid_rs);
  assign rt_match = ifid_uses_rt && (idex_rt == ifid_rt);

  // $zero is never really written, so a load into it cannot create a dependency.
  assign load_use = idex_memread && (idex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: load-use stalls, ID-resolved branch/jump flushes,
// and whole-pipeline freeze while a data cache access is outstanding.
// Latency: control outputs are combinational (act in the same cycle); counters and
//          timeout_o update on the clock edge.
// Backpressure: req/ack with the data cache; the pipeline stays frozen until ack.
// Ports: hazard inputs from IF/ID and ID/EX, branch/jump from ID, EX/MEM access
//        flags and dcache_ack_i in; register enables/stall/bubble controls,
//        dcache_req_o, saturating stall/flush counters and sticky timeout_o out.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             exmem_memread_i,
  input  logic             exmem_memwrite_i,
  input  logic             dcache_ack_i,
  output logic             dcache_req_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_bubble_o,
  output logic             exmem_stall_o,
  output logic             memwb_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_o
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state;
  state_t          state_nxt;
  logic            mem_acc;
  logic            freeze;
  logic            req;
  logic            load_use_raw;
  logic            load_use;
  logic            flush;
  logic [WC_W-1:0] wait_cnt;

  assign mem_acc = exmem_memread_i || exmem_memwrite_i;

  hazard_detect u_hazard_detect (
    .idex_memread (idex_memread_i),
    .idex_rt      (idex_rt_i),
    .ifid_rs      (ifid_rs_i),
    .ifid_rt      (ifid_rt_i),
    .ifid_uses_rt (ifid_uses_rt_i),
    .load_use     (load_use_raw)
  );

  // Handshake FSM: state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake FSM: next state plus request/freeze. An ack outside WAIT is ignored.
  // DONE lets the access instruction leave MEM before a new access can be seen.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    freeze    = 1'b0;
    case (state)
      RUN: begin
        if (mem_acc) begin
          req       = 1'b1;
          freeze    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        req    = 1'b1;
        freeze = 1'b1;
        if (dcache_ack_i) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Priority: freeze > load-use > flush. A suppressed branch is seen again later
  // because IF/ID is held while the higher-priority condition lasts.
  assign load_use = !freeze && load_use_raw;
  assign flush    = !freeze && !load_use && (branch_taken_i || jump_i);

  // Output mux. Reset forces a safe, combinational pattern so requests drop at once.
  always_comb begin
    dcache_req_o   = 1'b0;
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_stall_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_stall_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    if (!rst_n_i) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_bubble_o  = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (freeze) begin
      dcache_req_o   = req;
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_stall_o   = 1'b1;
      exmem_stall_o  = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (flush) begin
      ifid_flush_o = 1'b1;
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((freeze || load_use) && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (flush && (flush_cnt_o != CNT_MAX)) begin
        flush_cnt_o <= flush_cnt_o + 1'b1;
      end
    end
  end

  // Wait counter counts WAIT cycles without ack; it stops at TIMEOUT so it cannot
  // wrap and the FSM simply keeps waiting after timeout_o is raised.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state == RUN && state_nxt == WAIT) begin
        wait_cnt <= '0;
      end else if (state == WAIT && !dcache_ack_i && wait_cnt != WC_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == WAIT && !dcache_ack_i && wait_cnt == WC_LAST) begin
        timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a spec-level reference model checked every cycle.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_pipeline_ctrl;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [4:0]    ifid_rs;
  logic [4:0]    ifid_rt;
  logic          ifid_uses_rt;
  logic          idex_memread;
  logic [4:0]    idex_rt;
  logic          branch_taken;
  logic          jump;
  logic          exmem_memread;
  logic          exmem_memwrite;
  logic          dcache_ack;
  logic          dcache_req;
  logic          pc_write;
  logic          ifid_write;
  logic          ifid_flush;
  logic          idex_stall;
  logic          idex_bubble;
  logic          exmem_stall;
  logic          memwb_bubble;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic          timeout;

  int n_chk  = 0;
  int n_fail = 0;

  pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .ifid_rs_i        (ifid_rs),
    .ifid_rt_i        (ifid_rt),
    .ifid_uses_rt_i   (ifid_uses_rt),
    .idex_memread_i   (idex_memread),
    .idex_rt_i        (idex_rt),
    .branch_taken_i   (branch_taken),
    .jump_i           (jump),
    .exmem_memread_i  (exmem_memread),
    .exmem_memwrite_i (exmem_memwrite),
    .dcache_ack_i     (dcache_ack),
    .dcache_req_o     (dcache_req),
    .pc_write_o       (pc_write),
    .ifid_write_o     (ifid_write),
    .ifid_flush_o     (ifid_flush),
    .idex_stall_o     (idex_stall),
    .idex_bubble_o    (idex_bubble),
    .exmem_stall_o    (exmem_stall),
    .memwb_bubble_o   (memwb_bubble),
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt),
    .timeout_o        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: access bookkeeping as plain flags and integer counts.
  bit m_waiting;     // an access is outstanding with the cache
  bit m_finishing;   // the acked access is leaving MEM this cycle
  int m_wait;        // no-ack cycles spent waiting in the current access
  int m_stall;
  int m_flush;
  bit m_timeout;

  function automatic bit f_frozen();
    return m_waiting || (!m_finishing && (exmem_memread || exmem_memwrite));
  endfunction

  function automatic bit f_loaduse();
    return !f_frozen() && idex_memread && (idex_rt != 5'd0) &&
           ((idex_rt == ifid_rs) || (ifid_uses_rt && idex_rt == ifid_rt));
  endfunction

  function automatic bit f_flush();
    return !f_frozen() && !f_loaduse() && (branch_taken || jump);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_waiting = 0; m_finishing = 0; m_wait = 0;
      m_stall = 0; m_flush = 0; m_timeout = 0;
    end else begin
      bit fz, lu, fl;
      fz = f_frozen(); lu = f_loaduse(); fl = f_flush();
      if (fz || lu) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      if (fl)       m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
      if (m_finishing) begin
        m_finishing = 0;
      end else if (m_waiting) begin
        if (dcache_ack) begin
          m_waiting = 0;
          m_finishing = 1;
        end else begin
          m_wait++;
          if (m_wait >= TO) m_timeout = 1;
        end
      end else if (exmem_memread || exmem_memwrite) begin
        m_waiting = 1;
        m_wait = 0;
      end
    end
  end

  // Compare process: every output, every cycle, on the falling edge.
  always @(negedge clk) begin
    bit fz, lu, fl, rs;
    rs = !rst_n;
    fz = !rs && f_frozen();
    lu = !rs && f_loaduse();
    fl = !rs && f_flush();
    chk("cyc_dcache_req",   int'(dcache_req),   int'(fz));
    chk("cyc_pc_write",     int'(pc_write),     int'(!rs && !fz && !lu));
    chk("cyc_ifid_write",   int'(ifid_write),   int'(!rs && !fz && !lu));
    chk("cyc_ifid_flush",   int'(ifid_flush),   int'(fl));
    chk("cyc_idex_stall",   int'(idex_stall),   int'(fz));
    chk("cyc_idex_bubble",  int'(idex_bubble),  int'(rs || lu));
    chk("cyc_exmem_stall",  int'(exmem_stall),  int'(fz));
    chk("cyc_memwb_bubble", int'(memwb_bubble), int'(rs || fz));
    chk("cyc_stall_cnt",    int'(stall_cnt),    m_stall);
    chk("cyc_flush_cnt",    int'(flush_cnt),    m_flush);
    chk("cyc_timeout",      int'(timeout),      int'(m_timeout));
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit b2b_req [6];
    b2b_req = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0;
    idex_memread = 1'b0; idex_rt = '0;
    branch_taken = 1'b0; jump = 1'b0;
    exmem_memread = 1'b0; exmem_memwrite = 1'b0; dcache_ack = 1'b0;

    @(negedge clk);
    chk("rst_pc_write", int'(pc_write), 0);
    chk("rst_idex_bubble", int'(idex_bubble), 1);
    chk("rst_memwb_bubble", int'(memwb_bubble), 1);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    nxt(); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_pc_write", int'(pc_write), 1);

    // lw $2 ; add $3,$2,$4
    nxt(); idex_memread = 1'b1; idex_rt = 5'd2; ifid_rs = 5'd2; ifid_rt = 5'd4;
    @(negedge clk);
    chk("lu_pc_write", int'(pc_write), 0);
    chk("lu_idex_bubble", int'(idex_bubble), 1);
    nxt(); idex_memread = 1'b0;
    @(negedge clk);
    chk("lu_stall_cnt", int'(stall_cnt), 1);

    // lw $0 with a consumer of $0
    nxt(); idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    @(negedge clk);
    chk("zero_pc_write", int'(pc_write), 1);
    nxt(); idex_memread = 1'b0;
    @(negedge clk);
    chk("zero_stall_cnt", int'(stall_cnt), 1);

    // rt match only counts when rt is a source
    nxt(); idex_memread = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7;
    @(negedge clk);
    chk("rt_unused_pc_write", int'(pc_write), 1);
    nxt(); ifid_uses_rt = 1'b1;
    @(negedge clk);
    chk("rt_used_bubble", int'(idex_bubble), 1);
    nxt(); idex_memread = 1'b0; ifid_uses_rt = 1'b0;
    @(negedge clk);
    chk("rt_stall_cnt", int'(stall_cnt), 2);

    // taken beq
    nxt(); branch_taken = 1'b1;
    @(negedge clk);
    chk("br_flush", int'(ifid_flush), 1);
    chk("br_pc_write", int'(pc_write), 1);
    nxt(); branch_taken = 1'b0;
    @(negedge clk);
    chk("br_flush_cnt", int'(flush_cnt), 1);

    // load-use and taken branch together: stall first, flush next cycle
    nxt(); idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; branch_taken = 1'b1;
    @(negedge clk);
    chk("lubr_flush", int'(ifid_flush), 0);
    chk("lubr_bubble", int'(idex_bubble), 1);
    nxt(); idex_memread = 1'b0;
    @(negedge clk);
    chk("lubr_late_flush", int'(ifid_flush), 1);
    nxt(); branch_taken = 1'b0;
    @(negedge clk);
    chk("lubr_stall_cnt", int'(stall_cnt), 3);
    chk("lubr_flush_cnt", int'(flush_cnt), 2);

    // load with ack on the third WAIT cycle; ack in RUN ignored, jump while frozen suppressed
    nxt(); exmem_memread = 1'b1; dcache_ack = 1'b1;
    @(negedge clk);
    chk("mem_run_req", int'(dcache_req), 1);
    nxt(); dcache_ack = 1'b0; jump = 1'b1;
    @(negedge clk);
    chk("mem_w1_req", int'(dcache_req), 1);
    chk("mem_w1_flush", int'(ifid_flush), 0);
    nxt(); jump = 1'b0;
    @(negedge clk);
    chk("mem_w2_req", int'(dcache_req), 1);
    nxt(); dcache_ack = 1'b1;
    @(negedge clk);
    chk("mem_w3_stall", int'(exmem_stall), 1);
    nxt(); dcache_ack = 1'b0;
    @(negedge clk);
    chk("mem_done_req", int'(dcache_req), 0);
    chk("mem_done_pc_write", int'(pc_write), 1);
    nxt(); exmem_memread = 1'b0;
    @(negedge clk);
    chk("mem_stall_cnt", int'(stall_cnt), 7);
    chk("mem_flush_cnt", int'(flush_cnt), 2);

    // back-to-back stores with ack held high
    nxt(); exmem_memwrite = 1'b1; dcache_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_req", int'(dcache_req), int'(b2b_req[i]));
      nxt();
    end
    exmem_memwrite = 1'b0; dcache_ack = 1'b0;
    @(negedge clk);
    chk("b2b_stall_cnt", int'(stall_cnt), 11);

    // stall counter saturation
    nxt(); idex_memread = 1'b1; idex_rt = 5'd2; ifid_rs = 5'd2;
    for (int i = 0; i < 6; i++) nxt();
    idex_memread = 1'b0;
    @(negedge clk);
    chk("sat_stall_cnt", int'(stall_cnt), SAT);

    // no ack: timeout after TO WAIT cycles, then reset mid-WAIT
    nxt(); exmem_memread = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("to_before", int'(timeout), 0);
      nxt();
    end
    @(negedge clk);
    chk("to_set", int'(timeout), 1);
    chk("to_still_req", int'(dcache_req), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_req", int'(dcache_req), 0);
    chk("rstw_timeout", int'(timeout), 0);
    chk("rstw_stall_cnt", int'(stall_cnt), 0);
    nxt(); rst_n = 1'b1; exmem_memread = 1'b0;
    @(negedge clk);
    chk("rel_pc_write", int'(pc_write), 1);
    chk("rel_req", int'(dcache_req), 0);
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. It detects load-use hazards between IF/ID and ID/EX, squashes the IF/ID instruction on taken branches and jumps resolved in ID, and runs a request/acknowledge handshake with the data cache, freezing the whole pipeline while a MEM-stage access is outstanding. It drives the write enables, stall inputs and bubble inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and keeps saturating stall and flush statistics.

## Interface
- TIMEOUT, 1023: cycles in WAIT without ack before timeout_o is raised
- CNT_W, 16: width of the statistics counters
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- ifid_rs_i  in  5  rs field of the IF/ID instruction
- ifid_rt_i  in  5  rt field of the IF/ID instruction
- ifid_uses_rt_i  in  1  IF/ID instruction reads rt as a source
- idex_memread_i  in  1  ID/EX MemRead
- idex_rt_i  in  5  ID/EX destination rt
- branch_taken_i  in  1  branch resolved taken in ID
- jump_i  in  1  jump decoded in ID
- exmem_memread_i  in  1  EX/MEM MemRead
- exmem_memwrite_i  in  1  EX/MEM MemWrite
- dcache_ack_i  in  1  data cache has completed the access
- dcache_req_o  out  1  data cache access request
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  IF/ID loads a NOP
- idex_stall_o  out  1  ID/EX holds its contents (drives ID/EX stall_i)
- idex_bubble_o  out  1  ID/EX control fields load zero
- exmem_stall_o  out  1  EX/MEM holds its contents
- memwb_bubble_o  out  1  MEM/WB control fields load zero
- stall_cnt_o  out  CNT_W  cycles with any stall
- flush_cnt_o  out  CNT_W  cycles with ifid_flush_o high
- timeout_o  out  1  sticky: data cache did not answer within TIMEOUT

## Operation
- FSM states RUN, WAIT, DONE; reset state RUN.
- mem_acc = exmem_memread_i | exmem_memwrite_i.
- RUN: if mem_acc, then dcache_req_o=1, freeze, next WAIT; otherwise no freeze.
- WAIT: dcache_req_o=1, freeze; dcache_ack_i=1 → DONE; otherwise stay in WAIT.
- DONE: dcache_req_o=0, no freeze (the access instruction advances); next RUN unconditionally.
- Freeze: pc_write_o=0, ifid_write_o=0, idex_stall_o=1, exmem_stall_o=1, memwb_bubble_o=1, ifid_flush_o=0, idex_bubble_o=0.
- Load-use condition, evaluated only when not frozen: idex_memread_i & idex_rt_i≠0 & (idex_rt_i==ifid_rs_i | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)).
- Load-use response: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
- Flush condition: (branch_taken_i | jump_i), not frozen, and no load-use hazard. Response: ifid_flush_o=1; PC and IF/ID still load.
- Priority: freeze > load-use > flush. A suppressed branch is re-evaluated on a later cycle because IF/ID is held.
- Defaults when no condition applies: pc_write_o=1, ifid_write_o=1, all other control outputs 0.
- stall_cnt_o increments on every freeze or load-use cycle. flush_cnt_o increments on every flush cycle. Both counters saturate at 2^CNT_W−1.
- Wait counter: zeroed on entry to WAIT, increments each WAIT cycle. When it reaches TIMEOUT, timeout_o is set. timeout_o is cleared only by reset; the FSM stays in WAIT.

## Timing
- Every control output except the counters and timeout_o is combinational from the current state and inputs, so it acts in the same cycle.
- Minimum memory access: 2 frozen cycles (RUN, then WAIT with ack), then DONE advances. Each cycle without ack adds 1.
- An ack arriving in RUN or DONE is ignored.
- Back-to-back accesses: DONE advances the pipeline; the next mem_acc is seen in RUN the following cycle.
- While rst_n_i=0, regardless of clock:
  - state=RUN, counters=0, timeout_o=0
  - dcache_req_o=0, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0
  - idex_stall_o=0, idex_bubble_o=1, exmem_stall_o=0, memwb_bubble_o=1
- Reset asserted mid-WAIT drops dcache_req_o immediately.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum {RUN, WAIT, DONE}
  - REG_W=5
  - REG_ZERO=5'd0
- Sub-module hazard_detect: purely combinational load-use comparator, instantiated once.
- The FSM, counters and output mux live in pipeline_ctrl.

## Test plan
- lw $2 in ID/EX, add $3,$2,$4 in IF/ID → one cycle with pc_write_o=0, idex_bubble_o=1; stall_cnt_o=1.
- lw $0 in ID/EX, consumer reads $0 → no stall.
- Taken beq in ID → ifid_flush_o=1 for one cycle, pc_write_o=1; flush_cnt_o=1.
- exmem_memread_i=1, ack after 3 WAIT cycles → freeze 4 cycles, DONE on cycle 5, stall_cnt_o=4.
- Load-use and taken branch in the same cycle → load-use only. Then flush on the next cycle.
- Frozen access with TIMEOUT=4 and no ack → timeout_o=1 after 4 WAIT cycles. Reset mid-WAIT → dcache_req_o=0 at once; RUN after release.
